// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on a one-cycle strobe and
// serializes start, 8 data bits LSB first, optional parity and stop bit.
// Bit period and framing are latched per frame; all outputs are registered.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  FSM_CLK,
  input  logic                  FSM_RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_done
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [4:0]            edge_cnt, edge_cnt_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n;
  logic                  par_typ_q, par_typ_n;
  logic [4:0]            pl_q, pl_n;
  logic                  last_tick;
  logic                  tx_d, busy_d, done_d;

  assign last_tick = (edge_cnt == (pl_q - 5'd1));

  // State register
  always_ff @(posedge FSM_CLK or negedge FSM_RST) begin
    if (!FSM_RST) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state, counter and shadow-register update logic
  always_comb begin
    state_n    = state;
    edge_cnt_n = edge_cnt;
    bit_cnt_n  = bit_cnt;
    data_n     = data_q;
    par_en_n   = par_en_q;
    par_typ_n  = par_typ_q;
    pl_n       = pl_q;
    case (state)
      IDLE: begin
        if (DATA_VALID) begin
          state_n    = START;
          edge_cnt_n = '0;
          bit_cnt_n  = '0;
          data_n     = P_DATA;
          par_en_n   = PAR_EN;
          par_typ_n  = PAR_TYP;
          pl_n       = (Prescale == 5'd0) ? 5'd1 : Prescale;
        end
      end
      START: begin
        if (last_tick) begin
          edge_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          edge_cnt_n = edge_cnt + 5'd1;
        end
      end
      DATA: begin
        if (last_tick) begin
          edge_cnt_n = '0;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
            state_n   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          edge_cnt_n = edge_cnt + 5'd1;
        end
      end
      PARITY: begin
        if (last_tick) begin
          edge_cnt_n = '0;
          state_n    = STOP;
        end else begin
          edge_cnt_n = edge_cnt + 5'd1;
        end
      end
      STOP: begin
        if (last_tick) begin
          edge_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          edge_cnt_n = edge_cnt + 5'd1;
        end
      end
      default: begin
        state_n    = IDLE;
        edge_cnt_n = '0;
        bit_cnt_n  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe (one-clock latency from acceptance)
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_n != IDLE);
    done_d = (state == STOP) && last_tick;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_n[bit_cnt_n];
      PARITY:  tx_d = (^data_n) ^ par_typ_n;
      default: tx_d = 1'b1;
    endcase
  end

  // Counters, shadow registers and registered outputs
  always_ff @(posedge FSM_CLK or negedge FSM_RST) begin
    if (!FSM_RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      pl_q       <= '0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      edge_cnt   <= edge_cnt_n;
      bit_cnt    <= bit_cnt_n;
      data_q     <= data_n;
      par_en_q   <= par_en_n;
      par_typ_q  <= par_typ_n;
      pl_q       <= pl_n;
      TX_OUT     <= tx_d;
      Busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller for the serial link, the transmit-side counterpart of the receive path. It accepts a parallel byte with a single-cycle valid strobe and drives the line with a complete frame: start bit, 8 data bits LSB first, optional parity bit and stop bit. Per-frame timing and framing come from the same Prescale / PAR_EN configuration used on the receive side. It owns the serializer, parity generator, bit-period counter and line-output mux.

## Interface
- DATA_WIDTH, 8, payload bits per frame.
- FSM_CLK  input  1  clock; reset FSM_RST, asynchronous, active-low; clock FSM_CLK.
- FSM_RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  byte to transmit; sampled only on acceptance.
- DATA_VALID  input  1  request strobe; accepted only when Busy=0.
- PAR_EN  input  1  1 = insert parity bit; latched on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; latched on acceptance.
- Prescale  input  5  FSM_CLK cycles per bit; latched on acceptance; 0 treated as 1.
- TX_OUT  output  1  serial line, registered, idle high.
- Busy  output  1  registered; high from acceptance through the last stop-bit cycle.
- frame_done  output  1  registered single-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If DATA_VALID=1 at a clock edge:
  - latch P_DATA, PAR_EN, PAR_TYP and Prescale into shadow registers;
  - clear edge_cnt and bit_cnt;
  - go to START.
- START: TX_OUT=0 for Prescale cycles, then DATA.
- DATA: TX_OUT=shadow[bit_cnt], bit_cnt from 0 to DATA_WIDTH-1, each bit held Prescale cycles.
  - After bit DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY: TX_OUT = (^shadow) XOR latched PAR_TYP, held Prescale cycles, then STOP.
- STOP: TX_OUT=1 for Prescale cycles, then IDLE; frame_done pulses.
- edge_cnt runs 0..Pl-1, where Pl is the latched Prescale (Pl=1 when Prescale=0).
  - At edge_cnt=Pl-1, edge_cnt wraps to 0 and the bit advances.
  - Width is 5 bits; no overflow is possible.
- DATA_VALID while Busy=1 is ignored. There is no queue and no error flag.
- Changes on P_DATA, PAR_EN, PAR_TYP or Prescale during a frame have no effect on that frame.
- Illegal state encodings return to IDLE on the next edge with TX_OUT=1.

## Timing
- Reset (asynchronous, mid-frame included) forces:
  - state=IDLE; TX_OUT=1; Busy=0; frame_done=0;
  - edge_cnt=0; bit_cnt=0; shadow registers=0.
  - The frame in flight is abandoned. The line returns high immediately, with no truncated stop bit.
- Acceptance edge E0: TX_OUT=0 and Busy=1 are visible after E0. Latency is one clock.
- Frame length N = 1 + DATA_WIDTH + PAR_EN + 1 bits. Busy stays high for exactly N*Pl cycles.
- The same edge that ends the stop bit sets Busy=0, TX_OUT=1 and frame_done=1 for one cycle.
- Back-to-back frames: DATA_VALID held high continuously gets acceptance on the first IDLE cycle.
  - This gives exactly one idle-high cycle between frames. Inter-frame gap = 1 cycle + stop bit.
- DATA_VALID asserted in the same cycle Busy falls is accepted, because state is IDLE at that edge.
- Pl=1: every bit lasts one cycle. The frame is N cycles with no bubbles.

## Test plan
- Reset then idle: FSM_RST low → TX_OUT=1, Busy=0, frame_done=0. Hold 20 cycles with DATA_VALID=0 → outputs unchanged.
- Basic frame without parity:
  - Stimulus: Prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID.
  - Line: 0, 1,0,1,0,0,1,0,1, 1, each bit 8 cycles.
  - Busy high for 80 cycles; frame_done pulses once at cycle 80.
- Parity variants, Prescale=16, P_DATA=0x37 (five ones):
  - PAR_TYP=0 → parity bit 1.
  - PAR_TYP=1 → parity bit 0.
  - Busy high for 176 cycles.
- Latching and ignored requests:
  - Start a frame with 0x0F. Mid-frame, change P_DATA to 0xF0, Prescale to 4 and pulse DATA_VALID.
  - Required: frame still sends 0x0F at the original rate, and no second frame follows.
- Back-to-back with Prescale=0:
  - Hold DATA_VALID=1 with P_DATA=0x00 and PAR_EN=0.
  - Required: 10-cycle frames separated by exactly one TX_OUT=1 idle cycle, plus one frame_done per frame.
- Reset mid-frame:
  - Assert FSM_RST during DATA bit 3 → TX_OUT=1 and Busy=0 asynchronously.
  - After release, a new DATA_VALID produces a complete, correct frame.
